// File: rtl/fetch_stage_if.sv
// Fetch-stage handshake bundle: imem request/response, branch redirect, and the decode-facing instruction port.
// master = fetch stage side, slave = memory/decode/execute side.
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_misaligned;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, fetch_misaligned,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_en, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, fetch_misaligned,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_en, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch: PC + credit-limited imem reads, response -> instr_valid next cycle; stalls on credit/imem_req_ready/instr_ready.
// Optional misaligned-redirect trap (HALT) when FETCH_MISALIGN_CHECK_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);
  localparam int          AW  = $clog2(FIFO_DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding, drop_cnt, fifo_count;
  logic [AW-1:0] pcq_wr, pcq_rd, fifo_wr, fifo_rd;
  logic          instr_vld_q;
  logic [31:0]   pcq      [FIFO_DEPTH];
  logic [31:0]   fifo_dat [FIFO_DEPTH];
  logic [31:0]   fifo_pc  [FIFO_DEPTH];

  logic [CW+1:0] occupancy;
  logic          credit, redir, req_fire, rsp_drop, rsp_keep, push, pop, mis_redir;
  logic [CW-1:0] fifo_count_nxt;
  logic [31:0]   redirect_target;

  // Every word in flight, buffered or awaiting discard holds one FIFO slot.
  assign occupancy = {2'b00, outstanding} + {2'b00, fifo_count} + {2'b00, drop_cnt};
  assign credit    = occupancy < (CW+2)'(FIFO_DEPTH);

  assign redir           = bus.redirect_en && (state == RUN);
  assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;
  assign req_fire        = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_drop        = bus.imem_rsp_valid && (drop_cnt != '0);
  assign rsp_keep        = bus.imem_rsp_valid && (drop_cnt == '0) && (outstanding != '0);
  assign push            = rsp_keep && !redir;
  assign pop             = instr_vld_q && bus.instr_ready;
  assign fifo_count_nxt  = fifo_count + CW'(push) - CW'(pop);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned_q;
  assign mis_redir            = redir && (bus.redirect_pc[1:0] != 2'b00);
  assign bus.fetch_misaligned = misaligned_q;
`else
  assign mis_redir            = 1'b0;
  assign bus.fetch_misaligned = 1'b0;
`endif

  assign bus.imem_req_valid = (state == RUN) && credit && !bus.redirect_en;
  assign bus.imem_req_addr  = pc;
  assign bus.instr_valid    = instr_vld_q;
  assign bus.instr          = instr_vld_q ? fifo_dat[fifo_rd] : NOP;
  assign bus.instr_pc       = instr_vld_q ? fifo_pc[fifo_rd]  : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      instr_vld_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      case (state)
        BOOT:    state <= RUN;
        RUN:     if (mis_redir) state <= HALT;
        default: state <= state;
      endcase
`ifdef FETCH_MISALIGN_CHECK_EN
      if (mis_redir) misaligned_q <= 1'b1;
`endif
      if (redir) begin
        // Everything still in flight is now stale, including a response landing this cycle.
        pc          <= redirect_target;
        drop_cnt    <= drop_cnt + outstanding - CW'(bus.imem_rsp_valid);
        outstanding <= '0;
        pcq_wr      <= '0;
        pcq_rd      <= '0;
        fifo_count  <= '0;
        fifo_wr     <= '0;
        fifo_rd     <= '0;
        instr_vld_q <= 1'b0;
      end else begin
        if (req_fire) begin
          pc     <= pc + 32'd4;
          pcq_wr <= pcq_wr + 1'b1;
        end
        if (rsp_keep) pcq_rd <= pcq_rd + 1'b1;
        if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
        outstanding <= outstanding + CW'(req_fire) - CW'(rsp_keep);
        if (push) fifo_wr <= fifo_wr + 1'b1;
        if (pop)  fifo_rd <= fifo_rd + 1'b1;
        fifo_count  <= fifo_count_nxt;
        instr_vld_q <= (fifo_count_nxt != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire && !redir) pcq[pcq_wr] <= pc;
    if (push) begin
      fifo_dat[fifo_wr] <= bus.imem_rsp_data;
      fifo_pc[fifo_wr]  <= pcq[pcq_rd];
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage (FIFO_DEPTH=2): cycle table plus redirect/misalign/reset sequences.
module tb_fetch_stage;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] memq[$];

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ird, mrdy, rspen, redir;
    logic [31:0] rpc;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(input logic ird, input logic mrdy, input logic rspen, input logic redir,
                              input logic [31:0] rpc, input logic rv, input logic [31:0] addr,
                              input logic iv, input logic [31:0] ipc);
    vec_t v;
    v.ird = ird; v.mrdy = mrdy; v.rspen = rspen; v.redir = redir; v.rpc = rpc;
    v.rv = rv; v.addr = addr; v.iv = iv; v.ipc = ipc;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, memory answers in order one cycle after acceptance.
  task automatic step(input logic ird, input logic mrdy, input logic rspen, input logic redir,
                      input logic [31:0] rpc, input logic rel);
    @(negedge clk);
    if (rel) rst = 1'b1;
    bus.instr_ready    = ird;
    bus.imem_req_ready = mrdy;
    bus.redirect_en    = redir;
    bus.redirect_pc    = rpc;
    bus.imem_rsp_valid = rspen && (memq.size() != 0);
    bus.imem_rsp_data  = (memq.size() != 0) ? mem_word(memq[0]) : 32'h0;
    #1;
    if (bus.imem_rsp_valid) void'(memq.pop_front());
    if (rst && bus.imem_req_valid && bus.imem_req_ready) memq.push_back(bus.imem_req_addr);
  endtask

  task automatic chk_instr(input string tag, input logic iv, input logic [31:0] ipc);
    chk({tag, " instr_valid"}, {31'h0, bus.instr_valid}, {31'h0, iv});
    chk({tag, " instr"}, bus.instr, iv ? mem_word(ipc) : 32'h0000_0013);
    if (iv) chk({tag, " instr_pc"}, bus.instr_pc, ipc);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_valid"}, {31'h0, bus.imem_req_valid}, 32'h0);
    chk({tag, " req_addr"}, bus.imem_req_addr, 32'h0);
    chk({tag, " fetch_misaligned"}, {31'h0, bus.fetch_misaligned}, 32'h0);
    chk_instr(tag, L, 32'h0);
  endtask

  initial begin
    bus.instr_ready = 1'b0; bus.imem_req_ready = 1'b0; bus.redirect_en = 1'b0;
    bus.redirect_pc = 32'h0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;

    // ird mrdy rspen redir rpc | req_valid req_addr instr_valid instr_pc
    vecs[0]  = mk(H,H,H,L,32'h0,   L,32'h00, L,32'h00);
    vecs[1]  = mk(H,H,H,L,32'h0,   H,32'h00, L,32'h00);
    vecs[2]  = mk(H,H,H,L,32'h0,   H,32'h04, L,32'h00);
    vecs[3]  = mk(H,H,H,L,32'h0,   L,32'h08, H,32'h00);
    vecs[4]  = mk(H,H,H,L,32'h0,   H,32'h08, H,32'h04);
    vecs[5]  = mk(H,H,H,L,32'h0,   H,32'h0C, L,32'h00);
    vecs[6]  = mk(H,H,H,L,32'h0,   L,32'h10, H,32'h08);
    vecs[7]  = mk(L,H,H,L,32'h0,   H,32'h10, H,32'h0C);
    vecs[8]  = mk(L,H,H,L,32'h0,   L,32'h14, H,32'h0C);
    vecs[9]  = mk(L,H,H,L,32'h0,   L,32'h14, H,32'h0C);
    vecs[10] = mk(L,H,H,L,32'h0,   L,32'h14, H,32'h0C);
    vecs[11] = mk(H,H,H,L,32'h0,   L,32'h14, H,32'h0C);
    vecs[12] = mk(H,H,H,L,32'h0,   H,32'h14, H,32'h10);
    vecs[13] = mk(H,H,H,L,32'h0,   H,32'h18, L,32'h00);
    vecs[14] = mk(H,L,H,L,32'h0,   L,32'h1C, H,32'h14);
    vecs[15] = mk(H,L,H,L,32'h0,   H,32'h1C, H,32'h18);
    vecs[16] = mk(H,L,H,L,32'h0,   H,32'h1C, L,32'h00);
    vecs[17] = mk(H,L,H,L,32'h0,   H,32'h1C, L,32'h00);
    vecs[18] = mk(H,L,H,L,32'h0,   H,32'h1C, L,32'h00);
    vecs[19] = mk(H,L,H,L,32'h0,   H,32'h1C, L,32'h00);
    vecs[20] = mk(H,H,H,L,32'h0,   H,32'h1C, L,32'h00);
    vecs[21] = mk(H,H,H,L,32'h0,   H,32'h20, L,32'h00);
    vecs[22] = mk(H,H,L,L,32'h0,   L,32'h24, H,32'h1C);
    vecs[23] = mk(H,H,L,L,32'h0,   H,32'h24, L,32'h00);
    vecs[24] = mk(H,H,L,H,32'h100, L,32'h28, L,32'h00);
    vecs[25] = mk(H,H,H,L,32'h0,   L,32'h100, L,32'h00);
    vecs[26] = mk(H,H,H,L,32'h0,   H,32'h100, L,32'h00);
    vecs[27] = mk(H,H,H,L,32'h0,   H,32'h104, L,32'h00);
    vecs[28] = mk(H,H,H,L,32'h0,   L,32'h108, H,32'h100);
    vecs[29] = mk(H,H,H,L,32'h0,   H,32'h108, H,32'h104);

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");

    for (int i = 0; i < 30; i++) begin
      string tag;
      tag = $sformatf("c%0d", i);
      step(vecs[i].ird, vecs[i].mrdy, vecs[i].rspen, vecs[i].redir, vecs[i].rpc, i == 0);
      chk({tag, " req_valid"}, {31'h0, bus.imem_req_valid}, {31'h0, vecs[i].rv});
      chk({tag, " req_addr"}, bus.imem_req_addr, vecs[i].addr);
      chk_instr(tag, vecs[i].iv, vecs[i].ipc);
    end

    // Misaligned redirect to 0x102 while the response for 0x108 lands in the same cycle.
    step(H, H, H, H, 32'h102, L);
    chk("c30 req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
    step(H, H, H, L, 32'h0, L);
    chk_instr("c31", L, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("c31 fetch_misaligned", {31'h0, bus.fetch_misaligned}, 32'h1);
    chk("c31 req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
    step(H, H, H, L, 32'h0, L);
    chk("c32 req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
    step(H, H, H, L, 32'h0, L);
    chk("c33 req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
    chk_instr("c33", L, 32'h0);
`else
    chk("c31 fetch_misaligned", {31'h0, bus.fetch_misaligned}, 32'h0);
    chk("c31 req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
    chk("c31 req_addr", bus.imem_req_addr, 32'h100);
    step(H, H, H, L, 32'h0, L);
    chk("c32 req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
    chk("c32 req_addr", bus.imem_req_addr, 32'h104);
    step(H, H, H, L, 32'h0, L);
    chk_instr("c33", H, 32'h100);
`endif

    // Reset mid-burst with a response pending; outputs must drop immediately.
    step(H, H, H, L, 32'h0, L);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    memq.delete();
    bus.imem_rsp_valid = 1'b0;
    repeat (2) @(posedge clk);

    step(H, H, H, L, 32'h0, H);
    chk("r0 req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
    step(H, H, H, L, 32'h0, L);
    chk("r1 req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
    chk("r1 req_addr", bus.imem_req_addr, 32'h0);
    step(H, H, H, L, 32'h0, L);
    chk("r2 req_addr", bus.imem_req_addr, 32'h4);
    chk_instr("r2", L, 32'h0);
    step(H, H, H, L, 32'h0, L);
    chk_instr("r3", H, 32'h0);
    chk("r3 fetch_misaligned", {31'h0, bus.fetch_misaligned}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
